// File: rtl/rle_pkg.sv
// Shared types for the run-length encoder.
// Pair layout matches the decoder word format.
package rle_pkg;

  localparam int SYM_W_DEF = 8;
  localparam int CNT_W_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_FLUSH
  } state_t;

  typedef struct packed {
    logic [SYM_W_DEF-1:0] sym;
    logic [CNT_W_DEF-1:0] cnt;
  } pair_t;

  // Count 0 marks an unused slot.
  localparam pair_t PAD_PAIR = '0;

endpackage

// File: rtl/rle_pair_if.sv
// Pair handshake between run detector and packer.
// Valid/ready: a pair moves when both are high.
interface rle_pair_if;
  import rle_pkg::*;

  logic  valid;
  logic  ready;
  logic  last;
  pair_t pair;

  modport master (
    output valid,
    output last,
    output pair,
    input  ready
  );

  modport slave (
    input  valid,
    input  last,
    input  pair,
    output ready
  );

endinterface

// File: rtl/rle_pair_packer.sv
// Packs two (sym,cnt) pairs per 32-bit word.
// A last pair in slot 0 is padded out with PAD_PAIR.
module rle_pair_packer
  import rle_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  rle_pair_if.slave   pif,
  output logic [31:0] coded_data_bus,
  output logic        coded_valid,
  output logic        coded_last,
  input  logic        coded_ready
);

  pair_t slot;
  logic  slot_full;
  logic  take;

  // Only take a pair when the output register can absorb a word.
  assign pif.ready = !coded_valid || coded_ready;
  assign take      = pif.valid && pif.ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      slot           <= PAD_PAIR;
      slot_full      <= 1'b0;
      coded_data_bus <= '0;
      coded_valid    <= 1'b0;
      coded_last     <= 1'b0;
    end else begin
      if (coded_valid && coded_ready) begin
        coded_valid <= 1'b0;
        coded_last  <= 1'b0;
      end
      if (take) begin
        if (slot_full) begin
          coded_data_bus <= {slot, pif.pair};
          coded_valid    <= 1'b1;
          coded_last     <= pif.last;
          slot_full      <= 1'b0;
        end else if (pif.last) begin
          coded_data_bus <= {pif.pair, PAD_PAIR};
          coded_valid    <= 1'b1;
          coded_last     <= 1'b1;
        end else begin
          slot      <= pif.pair;
          slot_full <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/rle_encoder.sv
// Run-length encoder: run detection FSM feeding
// the pair packer that builds 32-bit coded words.
module rle_encoder
  import rle_pkg::*;
#(
  parameter int SYM_W = SYM_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [SYM_W-1:0] in_data,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  output logic [31:0]      coded_data_bus,
  output logic             coded_valid,
  output logic             coded_last,
  input  logic             coded_ready
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state;
  logic [SYM_W-1:0] cur_sym;
  logic [CNT_W-1:0] cur_cnt;
  logic             armed;
  logic             accept;
  logic             extend;

  rle_pair_if pif ();

  // armed keeps in_ready low while reset is held.
  assign in_ready = armed && (state != ST_FLUSH) && pif.ready;
  assign accept   = in_valid && in_ready;
  assign extend   = (state == ST_RUN) &&
                    (in_data == cur_sym) &&
                    (cur_cnt != CNT_MAX);

  always_comb begin
    pif.valid    = 1'b0;
    pif.last     = 1'b0;
    pif.pair.sym = cur_sym;
    pif.pair.cnt = cur_cnt;
    unique case (1'b1)
      state == ST_FLUSH: begin
        pif.valid = 1'b1;
        pif.last  = 1'b1;
      end
      state == ST_RUN: begin
        pif.valid = accept && !extend;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= ST_IDLE;
      cur_sym <= '0;
      cur_cnt <= '0;
      armed   <= 1'b0;
    end else begin
      armed <= 1'b1;
      unique case (state)
        ST_IDLE: begin
          if (accept) begin
            cur_sym <= in_data;
            cur_cnt <= CNT_ONE;
            state   <= in_last ? ST_FLUSH : ST_RUN;
          end
        end
        ST_RUN: begin
          if (accept) begin
            if (extend) begin
              cur_cnt <= cur_cnt + CNT_ONE;
            end else begin
              cur_sym <= in_data;
              cur_cnt <= CNT_ONE;
            end
            if (in_last) state <= ST_FLUSH;
          end
        end
        ST_FLUSH: begin
          if (pif.ready) begin
            state   <= ST_IDLE;
            cur_cnt <= '0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  rle_pair_packer u_packer (
    .clk            (clk),
    .reset_n        (reset_n),
    .pif            (pif),
    .coded_data_bus (coded_data_bus),
    .coded_valid    (coded_valid),
    .coded_last     (coded_last),
    .coded_ready    (coded_ready)
  );

endmodule

// File: tb/tb_rle_encoder.sv
// Directed and randomized bench for rle_encoder
// with a word scoreboard and a decoding reference.
module tb_rle_encoder;

  logic        clk;
  logic        reset_n;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_last;
  logic        in_ready;
  logic [31:0] coded_data_bus;
  logic        coded_valid;
  logic        coded_last;
  logic        coded_ready;

  int          vec;
  int          mis;
  logic [32:0] exp_q[$];
  logic [7:0]  in_q[$];
  logic [7:0]  dec_q[$];
  int          n_last_in;
  int          n_last_out;
  bit          chk_words;
  bit          stall;
  bit          done;
  logic [32:0] held;

  rle_encoder dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .in_data        (in_data),
    .in_valid       (in_valid),
    .in_last        (in_last),
    .in_ready       (in_ready),
    .coded_data_bus (coded_data_bus),
    .coded_valid    (coded_valid),
    .coded_last     (coded_last),
    .coded_ready    (coded_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(string tag, logic [63:0] got, logic [63:0] want);
    vec++;
    assert (got === want) else begin
      mis++;
      $error("FAIL %s got %0h want %0h", tag, got, want);
    end
  endtask

  task automatic take_word();
    logic [32:0] w;
    logic [7:0]  s;
    logic [7:0]  c;
    if (chk_words) begin
      check("exp_pending", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        w = exp_q.pop_front();
        check("word", {31'b0, coded_last, coded_data_bus}, {31'b0, w});
      end
    end
    for (int i = 0; i < 2; i++) begin
      s = coded_data_bus[31-16*i -: 8];
      c = coded_data_bus[23-16*i -: 8];
      if (c == 8'd0)
        check("pad", {54'b0, (i == 1), coded_last, s}, {54'b0, 2'b11, 8'h00});
      else
        repeat (c) dec_q.push_back(s);
    end
    if (coded_last) n_last_out++;
  endtask

  always @(negedge clk) begin
    if (!reset_n) begin
      stall = 1'b0;
    end else begin
      if (stall)
        check("hold_stable",
              {30'b0, coded_valid, coded_last, coded_data_bus},
              {30'b0, 1'b1, held});
      stall = 1'b0;
      if (coded_valid) begin
        if (coded_ready) begin
          take_word();
        end else begin
          stall = 1'b1;
          held  = {coded_last, coded_data_bus};
        end
      end
    end
  end

  task automatic send(input logic [7:0] s, input bit l);
    int n = 0;
    in_data  = s;
    in_valid = 1'b1;
    in_last  = l;
    @(negedge clk);
    while (!in_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("in_accept", 64'(in_ready), 64'd1);
    in_q.push_back(s);
    if (l) n_last_in++;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send_str(string str, bit l);
    for (int i = 0; i < str.len(); i++)
      send(str[i], l && (i == str.len() - 1));
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || n_last_out != n_last_in) && n < 5000) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("drain_exp", 64'(exp_q.size()), 64'd0);
    check("drain_last", 64'(n_last_out), 64'(n_last_in));
  endtask

  initial begin
    logic [7:0] stim[$];
    bit         lst[$];
    logic [7:0] s;
    int         len;
    int         n;

    vec = 0; mis = 0;
    n_last_in = 0; n_last_out = 0;
    chk_words = 1'b1;
    done = 1'b0;
    reset_n = 1'b0;
    in_valid = 1'b0;
    in_last = 1'b0;
    in_data = 8'h00;
    coded_ready = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 64'(coded_valid), 64'd0);
    check("rst_last", 64'(coded_last), 64'd0);
    check("rst_data", 64'(coded_data_bus), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    check("in_ready_up", 64'(in_ready), 64'd1);

    exp_q.push_back({1'b1, 32'h41073701});
    send_str("AAAAAAA7", 1'b1);
    drain();

    exp_q.push_back({1'b0, 32'h41014201});
    exp_q.push_back({1'b1, 32'h43010000});
    send_str("ABC", 1'b1);
    drain();

    exp_q.push_back({1'b1, 32'h5AFF5A2D});
    for (int i = 0; i < 300; i++) send(8'h5A, i == 299);
    drain();

    // Output stalled: word must hold and input must stay blocked.
    coded_ready = 1'b0;
    exp_q.push_back({1'b1, 32'h41024201});
    send_str("AAB", 1'b1);
    n = 0;
    while (!coded_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    repeat (10) begin
      check("stall_valid", 64'(coded_valid), 64'd1);
      check("stall_data", 64'(coded_data_bus), 64'h41024201);
      check("stall_in_ready", 64'(in_ready), 64'd0);
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    coded_ready = 1'b1;
    drain();

    // Reset with a half-filled word and an open run.
    send_str("CAAA", 1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    check("mid_rst_valid", 64'(coded_valid), 64'd0);
    check("mid_rst_data", 64'(coded_data_bus), 64'd0);
    check("mid_rst_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_in_ready", 64'(in_ready), 64'd1);
    exp_q.push_back({1'b1, 32'h42010000});
    send_str("B", 1'b1);
    drain();

    chk_words = 1'b0;
    in_q.delete();
    dec_q.delete();
    while (stim.size() < 1000) begin
      s   = 8'h61 + 8'($urandom_range(0, 2));
      len = ($urandom_range(0, 29) == 0) ? int'($urandom_range(256, 300))
                                         : int'($urandom_range(1, 6));
      repeat (len) begin
        if (stim.size() < 1000) begin
          stim.push_back(s);
          lst.push_back($urandom_range(0, 24) == 0);
        end
      end
    end
    lst[999] = 1'b1;

    fork
      begin
        for (int i = 0; i < 1000; i++) begin
          repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
          end
          send(stim[i], lst[i]);
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1;
          coded_ready = ($urandom_range(0, 3) != 0);
        end
        coded_ready = 1'b1;
      end
    join
    drain();

    check("rand_len", 64'(dec_q.size()), 64'(in_q.size()));
    for (int i = 0; i < in_q.size() && i < dec_q.size(); i++)
      check("rand_sym", 64'(dec_q[i]), 64'(in_q[i]));

    $display("== %0d vectors applied, %0d miscompares ==", vec, mis);
    $finish;
  end

endmodule

// File: doc/rle_encoder.md
RLE_ENCODER -- requirements
Module: rle_encoder

Interface
REQ-001 SHALL have parameter SYM_W, default 8, symbol width in bits.
REQ-002 SHALL have parameter CNT_W, default 8, run-count width in bits; maximum run is 2^CNT_W-1.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic is on the rising edge.
REQ-004 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port in_data, input, SYM_W, uncoded symbol.
REQ-006 SHALL have port in_valid, input, 1, in_data is valid.
REQ-007 SHALL have port in_last, input, 1, marks the final symbol of a message; qualified by in_valid.
REQ-008 SHALL have port in_ready, output, 1, the encoder accepts the symbol this cycle.
REQ-009 SHALL have port coded_data_bus, output, 32, packed word {sym0[31:24], cnt0[23:16], sym1[15:8], cnt1[7:0]}; this is the decoder input format.
REQ-010 SHALL have port coded_valid, output, 1, coded_data_bus is valid.
REQ-011 SHALL have port coded_last, output, 1, the final word of a message.
REQ-012 SHALL have port coded_ready, input, 1, the downstream decoder accepts the word.

Function
REQ-013 A transfer SHALL occur on the input when in_valid && in_ready, and on the output when coded_valid && coded_ready.
REQ-014 Once asserted, coded_valid SHALL hold until the word is accepted, and coded_data_bus/coded_last SHALL stay stable while coded_valid && !coded_ready.
REQ-015 The run FSM SHALL have three states:
- IDLE: no run is open.
- RUN: cur_sym/cur_cnt hold the open run.
- FLUSH: the final run of a message is pending emission.
REQ-016 In IDLE, an accepted symbol SHALL set cur_sym=in_data and cur_cnt=1, then go to RUN; if in_last is also set, it SHALL go to FLUSH instead.
REQ-017 In RUN, an accepted symbol equal to cur_sym with cur_cnt < max SHALL increment cur_cnt and emit nothing.
REQ-018 In RUN, an accepted symbol that differs from cur_sym, or arrives with cur_cnt == max, SHALL:
- emit the pair (cur_sym, cur_cnt) to the packer;
- restart the run with cur_sym=in_data, cur_cnt=1.
REQ-019 In RUN with in_last:
- If the last symbol extends the run (REQ-017 conditions), the FSM SHALL go to FLUSH with the updated count.
- Otherwise it SHALL emit the current pair, load the new symbol with count 1, and go to FLUSH.
REQ-020 In FLUSH, in_ready SHALL be 0; the FSM SHALL emit (cur_sym, cur_cnt) marked last, then return to IDLE.
REQ-021 in_ready SHALL be 0 whenever the packer cannot accept a pair in the same cycle; no pair is ever dropped or duplicated.
REQ-022 The packer SHALL place the first pair of each word in [31:16] and the second pair in [15:0].
REQ-023 If the pair marked last lands in the first slot, the packer SHALL fill [15:0] with 16'h0000 (count 0 means padding) and set coded_last.
REQ-024 Latency: a word SHALL be valid on the cycle after the pair completing it is emitted, given coded_ready was high.
REQ-025 Counts SHALL never be 0 except in padding, and SHALL never exceed max; a run longer than max SHALL split into consecutive pairs with the same symbol.

Reset
REQ-026 Asserting reset_n low SHALL asynchronously force:
- FSM to IDLE;
- cur_cnt=0;
- packer slot empty;
- coded_valid=0, coded_last=0, coded_data_bus=0, in_ready=0.
REQ-027 After reset_n is released, in_ready SHALL rise no later than the first rising clk edge.
REQ-028 A reset mid-message SHALL discard all partial runs and half-filled words.

Structure
REQ-029 Package rle_pkg SHALL hold:
- SYM_W and CNT_W defaults;
- the FSM state enum;
- the pair struct {sym, cnt};
- the PAD_PAIR constant.
REQ-030 The 2-pair-to-word packing with output register SHALL be the sub-module rle_pair_packer; run detection SHALL stay in rle_encoder.

Verification
REQ-031 Input "AAAAAAA","7" (last on "7"), coded_ready=1 -> one word 32'h41_07_37_01 with coded_last=1.
REQ-032 Input "A","B","C" (last on "C") -> word 41_01_42_01 with coded_last=0, then 43_01_00_00 with coded_last=1.
REQ-033 Input 300 × "Z" (last) -> word 5A_FF_5A_2D with coded_last=1.
REQ-034 Input "AAB" with coded_ready held 0 for 10 cycles -> coded_valid is high and coded_data_bus is stable (41_02_42_01) for all 10 cycles, in_ready stays 0, and no loss occurs.
REQ-035 Random in_valid/coded_ready throttling over 1000 random symbols -> a reference-model decode equals the input exactly.
REQ-036 Assert reset_n low mid-run after "AAA" -> coded_valid=0 immediately; the next message "B" (last) -> 42_01_00_00 with no stale "A" pair.
